pong_engine: RTL and testbench

//  Parametrised pong game core: field/paddle geometry, serve/point/game-over FSM, scoring, prescaled

---
 rtl/pong_pkg.sv | 18 +
 rtl/pong_tick_div.sv | 33 +++
 rtl/pong_engine.sv | 277 +++++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game core: FSM states, direction
// encoding and point pulse bit positions.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } pong_state_e;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int PT_P1 = 0;
    localparam int PT_P2 = 1;

endpackage

// File: rtl/pong_tick_div.sv
// Down-counting tick divider: strobes for one cycle every 'period' clocks,
// reloads from 'period' on terminal count or on 'clear'.
module pong_tick_div #(
    parameter int PERIOD_W = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (clear || tick) begin
            cnt_d = period - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= period - 1'b1;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_engine.sv
// Pong game core: serve/point/game-over FSM, ball and paddle motion, scoring.
// Optional PONG_SPEEDUP_EN: ball period shortens by one clock per paddle hit (floor 2).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_SERVE | ball centred and still, waiting for serve
//   ST_PLAY  | ball moves one cell per ball tick, bounces, hit tests
//   ST_POINT | ball frozen for POINT_HOLD ball ticks after a miss
//   ST_OVER  | a player reached WIN_SCORE; ball and paddles frozen
module pong_engine
    import pong_pkg::*;
#(
    parameter int WIDTH       = 80,
    parameter int HEIGHT      = 40,
    parameter int PADDLE_SIZE = 6,
    parameter int BALL_DIV    = 4,
    parameter int PADDLE_DIV  = 2,
    parameter int WIN_SCORE   = 7,
    parameter int POINT_HOLD  = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           up1,
    input  logic                           down1,
    input  logic                           up2,
    input  logic                           down2,
    input  logic                           serve,
    output logic [$clog2(WIDTH)-1:0]       ball_x,
    output logic [$clog2(HEIGHT)-1:0]      ball_y,
    output logic [$clog2(HEIGHT)-1:0]      paddle1_y,
    output logic [$clog2(HEIGHT)-1:0]      paddle2_y,
    output logic [$clog2(WIN_SCORE+1)-1:0] score1,
    output logic [$clog2(WIN_SCORE+1)-1:0] score2,
    output logic [1:0]                     point_p,
    output logic                           game_over
);

    localparam int X_W    = $clog2(WIDTH);
    localparam int Y_W    = $clog2(HEIGHT);
    localparam int S_W    = $clog2(WIN_SCORE + 1);
    localparam int BCNT_W = $clog2(BALL_DIV + 1);
    localparam int PCNT_W = $clog2(PADDLE_DIV + 1);
    localparam int HOLD_W = $clog2(POINT_HOLD + 1);

    localparam logic [X_W-1:0]    X_MID     = X_W'(WIDTH / 2);
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [X_W-1:0]    X_P1      = X_W'(1);
    localparam logic [X_W-1:0]    X_P2      = X_W'(WIDTH - 2);
    localparam logic [Y_W-1:0]    Y_MID     = Y_W'(HEIGHT / 2);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [Y_W-1:0]    PAD_RST   = Y_W'(HEIGHT / 2 - PADDLE_SIZE / 2);
    localparam logic [Y_W-1:0]    PAD_MAX   = Y_W'(HEIGHT - PADDLE_SIZE);
    localparam logic [Y_W:0]      PAD_SPAN  = (Y_W + 1)'(PADDLE_SIZE - 1);
    localparam logic [S_W-1:0]    SC_WIN    = S_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(POINT_HOLD - 1);

    pong_state_e       state_q, state_d;
    logic [X_W-1:0]    ball_x_q, ball_x_d;
    logic [Y_W-1:0]    ball_y_q, ball_y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic              dir_y_nx;
    logic [Y_W-1:0]    paddle1_q, paddle1_d;
    logic [Y_W-1:0]    paddle2_q, paddle2_d;
    logic [S_W-1:0]    score1_q, score1_d;
    logic [S_W-1:0]    score2_q, score2_d;
    logic [S_W-1:0]    score1_inc, score2_inc;
    logic [1:0]        point_p_q, point_p_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic              ball_tick;
    logic              paddle_tick;
    logic              ball_clear;
    logic              enter_serve;
    logic              hit1, hit2;
    logic [BCNT_W-1:0] ball_period;

    function automatic logic [Y_W-1:0] paddle_step(input logic [Y_W-1:0] p,
                                                   input logic up,
                                                   input logic dn);
        paddle_step = p;
        if (up && !dn && p != '0) begin
            paddle_step = p - 1'b1;
        end else if (dn && !up && p < PAD_MAX) begin
            paddle_step = p + 1'b1;
        end
    endfunction

    pong_tick_div #(.PERIOD_W(BCNT_W)) u_ball_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (ball_clear),
        .period  (ball_period),
        .tick    (ball_tick)
    );

    pong_tick_div #(.PERIOD_W(PCNT_W)) u_paddle_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .period  (PCNT_W'(PADDLE_DIV)),
        .tick    (paddle_tick)
    );

    // Hit tests use the paddle position before this cycle's paddle move.
    assign hit1 = (ball_y_q >= paddle1_q) &&
                  ({1'b0, ball_y_q} <= ({1'b0, paddle1_q} + PAD_SPAN));
    assign hit2 = (ball_y_q >= paddle2_q) &&
                  ({1'b0, ball_y_q} <= ({1'b0, paddle2_q} + PAD_SPAN));

    assign score1_inc = (score1_q == SC_WIN) ? score1_q : score1_q + 1'b1;
    assign score2_inc = (score2_q == SC_WIN) ? score2_q : score2_q + 1'b1;

`ifdef PONG_SPEEDUP_EN
    logic [BCNT_W-1:0] speed_q, speed_d;
    logic              paddle_hit;

    assign paddle_hit = ball_tick && (state_q == ST_PLAY) &&
                        ((ball_x_q == X_P1 && dir_x_q == DIR_NEG && hit1) ||
                         (ball_x_q == X_P2 && dir_x_q == DIR_POS && hit2));

    always_comb begin
        speed_d = speed_q;
        if (enter_serve) begin
            speed_d = BCNT_W'(BALL_DIV);
        end else if (paddle_hit && speed_q > BCNT_W'(2)) begin
            speed_d = speed_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            speed_q <= BCNT_W'(BALL_DIV);
        end else begin
            speed_q <= speed_d;
        end
    end

    // Feed the next speed so the reload on a hit tick already uses it.
    assign ball_period = speed_d;
`else
    assign ball_period = BCNT_W'(BALL_DIV);
`endif

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        dir_y_nx    = dir_y_q;
        paddle1_d   = paddle1_q;
        paddle2_d   = paddle2_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        point_p_d   = '0;
        hold_d      = hold_q;
        ball_clear  = 1'b0;
        enter_serve = 1'b0;

        if (paddle_tick && state_q != ST_OVER) begin
            paddle1_d = paddle_step(paddle1_q, up1, down1);
            paddle2_d = paddle_step(paddle2_q, up2, down2);
        end

        case (state_q)
            ST_SERVE: begin
                if (serve) begin
                    state_d    = ST_PLAY;
                    ball_clear = 1'b1;
                end
            end
            ST_PLAY: begin
                if (ball_tick) begin
                    if ((ball_y_q == '0 && dir_y_q == DIR_NEG) ||
                        (ball_y_q == Y_LAST && dir_y_q == DIR_POS)) begin
                        dir_y_nx = ~dir_y_q;
                    end
                    dir_y_d  = dir_y_nx;
                    ball_y_d = (dir_y_nx == DIR_POS) ? ball_y_q + 1'b1 : ball_y_q - 1'b1;

                    if (ball_x_q == X_P1 && dir_x_q == DIR_NEG) begin
                        if (hit1) begin
                            dir_x_d  = DIR_POS;
                            ball_x_d = X_P1 + 1'b1;
                        end else begin
                            ball_x_d         = '0;
                            dir_x_d          = DIR_NEG;
                            score2_d         = score2_inc;
                            point_p_d[PT_P2] = 1'b1;
                            hold_d           = HOLD_LOAD;
                            state_d          = (score2_inc == SC_WIN) ? ST_OVER : ST_POINT;
                        end
                    end else if (ball_x_q == X_P2 && dir_x_q == DIR_POS) begin
                        if (hit2) begin
                            dir_x_d  = DIR_NEG;
                            ball_x_d = X_P2 - 1'b1;
                        end else begin
                            ball_x_d         = X_LAST;
                            dir_x_d          = DIR_POS;
                            score1_d         = score1_inc;
                            point_p_d[PT_P1] = 1'b1;
                            hold_d           = HOLD_LOAD;
                            state_d          = (score1_inc == SC_WIN) ? ST_OVER : ST_POINT;
                        end
                    end else begin
                        ball_x_d = (dir_x_q == DIR_POS) ? ball_x_q + 1'b1 : ball_x_q - 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (ball_tick) begin
                    if (hold_q == '0) begin
                        state_d     = ST_SERVE;
                        enter_serve = 1'b1;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (serve) begin
                    state_d     = ST_SERVE;
                    enter_serve = 1'b1;
                    score1_d    = '0;
                    score2_d    = '0;
                end
            end
            default: state_d = ST_SERVE;
        endcase

        // dir_x already points at the loser of the last point.
        if (enter_serve) begin
            ball_x_d = X_MID;
            ball_y_d = Y_MID;
            dir_y_d  = DIR_POS;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_SERVE;
            ball_x_q  <= X_MID;
            ball_y_q  <= Y_MID;
            dir_x_q   <= DIR_POS;
            dir_y_q   <= DIR_POS;
            paddle1_q <= PAD_RST;
            paddle2_q <= PAD_RST;
            score1_q  <= '0;
            score2_q  <= '0;
            point_p_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            paddle1_q <= paddle1_d;
            paddle2_q <= paddle2_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            point_p_q <= point_p_d;
            hold_q    <= hold_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign paddle1_y = paddle1_q;
    assign paddle2_y = paddle2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point_p   = point_p_q;
    assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine: a game-level model predicts every cycle's
// outputs and every point pulse; a monitor compares them after each clock edge.
module tb_pong_engine;

    localparam int W  = 80;
    localparam int H  = 40;
    localparam int PS = 6;
    localparam int BD = 4;
    localparam int PD = 2;
    localparam int WS = 7;
    localparam int PH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0, serve = 1'b0;
    logic [6:0] ball_x;
    logic [5:0] ball_y, paddle1_y, paddle2_y;
    logic [2:0] score1, score2;
    logic [1:0] point_p;
    logic       game_over;

    pong_engine dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .up1       (up1),
        .down1     (down1),
        .up2       (up2),
        .down2     (down2),
        .serve     (serve),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .paddle1_y (paddle1_y),
        .paddle2_y (paddle2_y),
        .score1    (score1),
        .score2    (score2),
        .point_p   (point_p),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] bx;
        logic [5:0] by;
        logic [5:0] p1;
        logic [5:0] p2;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [1:0] pp;
        logic       go;
    } snap_t;

    snap_t      exp_q[$];
    logic [1:0] pt_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_hits = 0, n_points = 0, n_games = 0;

    // Game model: positions and scores as plain integers, mode as a name.
    int    m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_pp, m_hold, m_pc, m_bc;
    string m_mode;

    function automatic int pmove(input int p, input bit u, input bit d);
        if (u && !d && p > 0) return p - 1;
        if (d && !u && p < H - PS) return p + 1;
        return p;
    endfunction

    task automatic model_reset();
        m_bx = W / 2; m_by = H / 2; m_dx = 1; m_dy = 1;
        m_p1 = H / 2 - PS / 2; m_p2 = H / 2 - PS / 2;
        m_s1 = 0; m_s2 = 0; m_pp = 0; m_hold = 0;
        m_pc = 0; m_bc = 0; m_mode = "serve";
    endtask

    task automatic enter_serve();
        m_mode = "serve"; m_bx = W / 2; m_by = H / 2; m_dy = 1;
    endtask

    task automatic award(input int p);
        bit won;
        n_points++;
        if (p == 1) begin
            if (m_s1 < WS) m_s1++;
            m_pp = 1; m_dx = 1; pt_q.push_back(2'b01); won = (m_s1 == WS);
        end else begin
            if (m_s2 < WS) m_s2++;
            m_pp = 2; m_dx = -1; pt_q.push_back(2'b10); won = (m_s2 == WS);
        end
        if (won) begin
            m_mode = "over"; n_games++;
        end else begin
            m_mode = "point"; m_hold = PH;
        end
    endtask

    task automatic model_step(input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
        int oy, op1, op2;
        bit ptick, btick;
        m_pp = 0;
        oy = m_by; op1 = m_p1; op2 = m_p2;
        m_pc++;
        ptick = (m_pc % PD) == 0;
        if (m_mode == "serve" && sv) begin
            m_bc = 0; btick = 0;
        end else begin
            m_bc++; btick = (m_bc % BD) == 0;
        end
        if (m_mode != "over" && ptick) begin
            m_p1 = pmove(m_p1, u1, d1);
            m_p2 = pmove(m_p2, u2, d2);
        end
        if (m_mode == "serve") begin
            if (sv) m_mode = "play";
        end else if (m_mode == "play") begin
            if (btick) begin
                if ((oy == 0 && m_dy < 0) || (oy == H - 1 && m_dy > 0)) m_dy = -m_dy;
                m_by = oy + m_dy;
                if (m_bx == 1 && m_dx < 0) begin
                    if (oy >= op1 && oy <= op1 + PS - 1) begin
                        m_dx = 1; m_bx = 2; n_hits++;
                    end else begin
                        m_bx = 0; award(2);
                    end
                end else if (m_bx == W - 2 && m_dx > 0) begin
                    if (oy >= op2 && oy <= op2 + PS - 1) begin
                        m_dx = -1; m_bx = W - 3; n_hits++;
                    end else begin
                        m_bx = W - 1; award(1);
                    end
                end else begin
                    m_bx += m_dx;
                end
            end
        end else if (m_mode == "point") begin
            if (btick) begin
                m_hold--;
                if (m_hold == 0) enter_serve();
            end
        end else begin
            if (sv) begin
                m_s1 = 0; m_s2 = 0; enter_serve();
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        s.bx = 7'(m_bx); s.by = 6'(m_by); s.p1 = 6'(m_p1); s.p2 = 6'(m_p2);
        s.s1 = 3'(m_s1); s.s2 = 3'(m_s2); s.pp = 2'(m_pp); s.go = (m_mode == "over");
        return s;
    endfunction

    task automatic drive(input bit rst, input bit u1, input bit d1, input bit u2, input bit d2, input bit sv);
        @(negedge clk);
        reset_n = !rst;
        up1 = u1; down1 = d1; up2 = u2; down2 = d2; serve = sv;
        if (rst) model_reset();
        else model_step(u1, d1, u2, d2, sv);
        exp_q.push_back(model_snap());
    endtask

    // Policy 0: idle, 1: follow the ball, 2: random buttons.
    task automatic player(input int pol, input int p, output bit u, output bit d);
        u = 1'b0; d = 1'b0;
        if (pol == 1) begin
            if (m_by < p + 2) u = 1'b1;
            else if (m_by > p + 3) d = 1'b1;
        end else if (pol == 2) begin
            u = 1'($urandom_range(1));
            d = 1'($urandom_range(1));
        end
    endtask

    task automatic run_seg(input int ncyc, input int pol1, input int pol2, input int serve_pct);
        for (int i = 0; i < ncyc; i++) begin
            bit u1, d1, u2, d2, sv;
            player(pol1, m_p1, u1, d1);
            player(pol2, m_p2, u2, d2);
            sv = ($urandom_range(99) < serve_pct);
            drive(1'b0, u1, d1, u2, d2, sv);
        end
    endtask

    initial begin
        snap_t e, a;
        logic [1:0] ep;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{ball_x, ball_y, paddle1_y, paddle2_y, score1, score2, point_p, game_over};
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d pt=%b go=%b required bx=%0d by=%0d p1=%0d p2=%0d s1=%0d s2=%0d pt=%b go=%b",
                             $time, a.bx, a.by, a.p1, a.p2, a.s1, a.s2, a.pp, a.go,
                             e.bx, e.by, e.p1, e.p2, e.s1, e.s2, e.pp, e.go);
                end
            end
            if (point_p != 2'b00) begin
                n_checks++;
                if (pt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL point_event t=%0t got pulse %b required none", $time, point_p);
                end else begin
                    ep = pt_q.pop_front();
                    if (point_p !== ep) begin
                        n_fail++;
                        $display("FAIL point_event t=%0t got %b required %b", $time, point_p, ep);
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) drive(1'b1, 0, 0, 0, 0, 0);
        repeat (20) drive(1'b0, 0, 0, 0, 0, 0);
        repeat (130) drive(1'b0, 0, 1, 0, 0, 0);
        repeat (20) drive(1'b0, 1, 1, 0, 1, 0);
        repeat (60) drive(1'b0, 1, 0, 0, 0, 0);
        run_seg(3000, 1, 1, 2);
        run_seg(6000, 1, 0, 30);
        for (int s = 0; s < 12; s++) begin
            if ($urandom_range(9) == 0) drive(1'b1, 0, 0, 0, 0, 0);
            run_seg(int'($urandom_range(1500, 400)), int'($urandom_range(2)),
                    int'($urandom_range(2)), int'($urandom_range(60, 2)));
        end
        repeat (4) drive(1'b0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_outputs got %0d pending required 0", exp_q.size());
        end
        n_checks++;
        if (pt_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_points got %0d missing pulses required 0", pt_q.size());
        end
        $display("Model activity: hits=%0d points=%0d games=%0d", n_hits, n_points, n_games);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
